doodle_physics: RTL

- Parametrised successor to the single-ground doodle position logic.
- Holds the player position and a signed vertical velocity, generates the frame tick, and integrates motion once per frame.
- Resolves landing against NUM_PLATFORMS platforms with a sequential scan of one platform per clock.
- Drives doodle_x/doodle_y to the sprite renderer; reports jump and game-over events to the game controller.

---
 rtl/doodle_pkg.sv | 21 ++
 rtl/frame_ticker.sv | 31 +++
 rtl/doodle_physics.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/doodle_pkg.sv
// Shared types and coordinate widths for the doodle physics blocks.
package doodle_pkg;

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = 12;

    typedef enum logic [2:0] {
        StWaitStart,
        StFlight,
        StScan,
        StUpdate,
        StGameOver
    } state_e;

    typedef struct packed {
        logic [9:0] y;
        logic [9:0] x;
    } platform_t;

endpackage

// File: rtl/frame_ticker.sv
// Free-running frame-rate divider: a one-cycle tick every CLK/FPS clocks.
module frame_ticker #(
    parameter int unsigned CLK = 50000000,
    parameter int unsigned FPS = 50
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned Period = CLK / FPS;
    localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;

    logic [CntW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntW'(Period - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/doodle_physics.sv
// Doodle player physics: per-frame motion integration with a one-platform-per-clock
// landing scan; position only changes in UPDATE so the renderer sees a stable frame.
module doodle_physics
    import doodle_pkg::*;
#(
    parameter int unsigned NUM_PLATFORMS = 4,
    parameter int unsigned SPRITE_W      = 80,
    parameter int unsigned SPRITE_H      = 80,
    parameter int unsigned PLATFORM_W    = 100,
    parameter int unsigned PLATFORM_H    = 30,
    parameter int unsigned VELOCITY      = 44,
    parameter int unsigned ACCELERATION  = 4,
    parameter int unsigned MAX_FALL      = 40,
    parameter int unsigned X_MIN         = 300,
    parameter int unsigned X_MAX         = 642,
    parameter int unsigned Y_FLOOR       = 767,
    parameter int unsigned SCREEN_H      = 768,
    parameter int unsigned START_X       = 472,
    parameter int unsigned START_Y       = 687,
    parameter int unsigned FPS           = 50,
    parameter int unsigned CLK           = 50000000
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_PLATFORMS-1:0][1:0][9:0] i_platforms,
    input  logic signed [8:0]                  i_delta_x,
    output logic [XW-1:0]                      o_doodle_x,
    output logic [YW-1:0]                      o_doodle_y,
    output logic signed [9:0]                  o_vel_y,
    output logic                               o_frame_tick,
    output logic                               o_jumped,
    output logic                               o_game_over,
    output logic                               o_busy
);

    localparam int unsigned IdxW = (NUM_PLATFORMS > 1) ? $clog2(NUM_PLATFORMS) : 1;

    if (CLK / FPS <= NUM_PLATFORMS + 2) begin : g_period_check
        $error("frame period too short for the platform scan");
    end

    state_e            r_state;
    logic [XW-1:0]     r_x, r_cx;
    logic [YW-1:0]     r_y, r_hit_y;
    logic [CW-1:0]     r_cy;
    logic signed [9:0] r_vel;
    logic [IdxW-1:0]   r_idx;
    logic              r_hit, r_jumped, r_game_over, r_busy;
    logic              w_tick;

    frame_ticker #(
        .CLK (CLK),
        .FPS (FPS)
    ) u_ticker (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    logic [XW-1:0]        w_x_step, w_cx;
    logic signed [CW-1:0] w_y_step;
    logic [CW-1:0]        w_cy;

    assign w_x_step = r_x + {{(XW-9){i_delta_x[8]}}, i_delta_x};
    assign w_y_step = $signed({{(CW-YW){1'b0}}, r_y}) + $signed({{(CW-10){r_vel[9]}}, r_vel});
    assign w_cy     = w_y_step[CW-1] ? '0 : $unsigned(w_y_step);

    always_comb begin
        if (r_x <= XW'(X_MIN)) begin
            w_cx = XW'(X_MAX - 1);
        end else if (r_x >= XW'(X_MAX)) begin
            w_cx = XW'(X_MIN + 1);
        end else begin
            w_cx = w_x_step;
        end
    end

    platform_t     w_plat;
    logic [CW-1:0] w_py, w_px, w_cx_ext, w_bot;
    logic          w_band, w_x_overlap, w_hit, w_fall_out;

    always_comb begin
        w_plat.y = i_platforms[r_idx][0];
        w_plat.x = i_platforms[r_idx][1];
    end

    assign w_py        = CW'(w_plat.y);
    assign w_px        = CW'(w_plat.x);
    assign w_cx_ext    = CW'(r_cx);
    assign w_bot       = r_cy + CW'(SPRITE_H);
    assign w_band      = (w_py <= w_bot) && (w_bot <= w_py + CW'(PLATFORM_H));
    // A platform at or below the floor line catches the sprite at any x.
    assign w_x_overlap = (w_py >= CW'(Y_FLOOR)) ||
                         ((w_px <= w_cx_ext + CW'(SPRITE_W - 1)) &&
                          (w_cx_ext <= w_px + CW'(PLATFORM_W - 1)));
    assign w_hit       = !r_vel[9] && w_band && w_x_overlap;
    assign w_fall_out  = w_bot > CW'(SCREEN_H);

    logic signed [10:0] w_vel_acc;
    logic signed [9:0]  w_vel_next;

    assign w_vel_acc  = $signed({r_vel[9], r_vel}) + $signed(11'(ACCELERATION));
    assign w_vel_next = (w_vel_acc > $signed(11'(MAX_FALL))) ? 10'(MAX_FALL) : w_vel_acc[9:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StWaitStart;
            r_x         <= XW'(START_X);
            r_y         <= YW'(START_Y);
            r_vel       <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_hit_y     <= '0;
            r_jumped    <= 1'b0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_jumped <= 1'b0;
            unique case (r_state)
                StWaitStart: begin
                    if (i_delta_x != '0) r_state <= StFlight;
                end
                StFlight: begin
                    if (w_tick) begin
                        r_cx    <= w_cx;
                        r_cy    <= w_cy;
                        r_idx   <= '0;
                        r_hit   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= StScan;
                    end
                end
                StScan: begin
                    if (w_hit && !r_hit) begin
                        r_hit   <= 1'b1;
                        r_hit_y <= w_plat.y;
                    end
                    if (r_idx == IdxW'(NUM_PLATFORMS - 1)) begin
                        r_state <= StUpdate;
                    end else begin
                        r_idx <= r_idx + IdxW'(1);
                    end
                end
                StUpdate: begin
                    r_x     <= r_cx;
                    r_busy  <= 1'b0;
                    r_state <= StFlight;
                    if (r_hit) begin
                        r_y      <= r_hit_y - YW'(SPRITE_H + 1);
                        r_vel    <= 10'(0) - 10'(VELOCITY);
                        r_jumped <= 1'b1;
                    end else if (w_fall_out) begin
                        r_y         <= r_cy[YW-1:0];
                        r_game_over <= 1'b1;
                        r_state     <= StGameOver;
                    end else begin
                        r_y   <= r_cy[YW-1:0];
                        r_vel <= w_vel_next;
                    end
                end
                StGameOver: begin
                    r_state <= StGameOver;
                end
                default: r_state <= StWaitStart;
            endcase
        end
    end

    assign o_doodle_x   = r_x;
    assign o_doodle_y   = r_y;
    assign o_vel_y      = r_vel;
    assign o_frame_tick = w_tick;
    assign o_jumped     = r_jumped;
    assign o_game_over  = r_game_over;
    assign o_busy       = r_busy;

endmodule
